// File: rtl/traffic_phase_arbiter.sv
// Demand-driven NS/EW intersection sequencer with an all-red pedestrian walk phase.
// Phase timing advances on ce ticks; request flags are latched on every clock.
module traffic_phase_arbiter #(
  parameter int _lightsWidth         = 6,
  parameter int _greenLightTimeWidth = 6,
  parameter int _timeLeftWidth       = 7,
  parameter int YELLOW_TIME          = 3,
  parameter int CLEAR_TIME           = 1,
  parameter int MIN_GREEN            = 4,
  parameter int PED_TIME             = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic                            reqNS,
  input  logic                            reqEW,
  input  logic                            pedReq,
  input  logic [_greenLightTimeWidth-1:0] greenLightTime,
  output logic [_lightsWidth-1:0]         lights,
  output logic                            walk,
  output logic [_timeLeftWidth-1:0]       timeLeftNS,
  output logic [_timeLeftWidth-1:0]       timeLeftEW
);

  localparam int TW = _timeLeftWidth;

  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_TIME);
  localparam logic [TW-1:0] T_CLEAR  = TW'(CLEAR_TIME);
  localparam logic [TW-1:0] T_MIN_G  = TW'(MIN_GREEN);
  localparam logic [TW-1:0] T_PED    = TW'(PED_TIME);

  localparam logic [_lightsWidth-1:0] L_ALL_RED   = _lightsWidth'(6'b100_100);
  localparam logic [_lightsWidth-1:0] L_NS_GREEN  = _lightsWidth'(6'b001_100);
  localparam logic [_lightsWidth-1:0] L_NS_YELLOW = _lightsWidth'(6'b010_100);
  localparam logic [_lightsWidth-1:0] L_EW_GREEN  = _lightsWidth'(6'b100_001);
  localparam logic [_lightsWidth-1:0] L_EW_YELLOW = _lightsWidth'(6'b100_010);

  typedef enum logic [2:0] {
    ALL_RED,
    NS_GREEN,
    NS_YELLOW,
    NS_CLEAR,
    EW_GREEN,
    EW_YELLOW,
    EW_CLEAR,
    PED_WALK
  } state_t;

  typedef enum logic {
    DIR_NS,
    DIR_EW
  } dir_t;

  state_t          state, state_nx;
  state_t          sel_veh, sel_any;
  logic [TW-1:0]   timer, timer_nx;
  logic [TW-1:0]   green_len;
  dir_t            last_dir, last_dir_nx;
  logic            pend_ns, pend_ew, pend_ped;
  logic            enter_ns, enter_ew, enter_ped;
  logic            opp_pend, same_pend;

  logic [_lightsWidth-1:0] lights_nx;
  logic                    walk_nx;
  logic [TW-1:0]           time_ns_nx, time_ew_nx;

  function automatic logic [TW-1:0] phase_len(input state_t s, input logic [TW-1:0] g);
    logic [TW-1:0] len;
    case (s)
      NS_GREEN, EW_GREEN:   len = g;
      NS_YELLOW, EW_YELLOW: len = T_YELLOW;
      PED_WALK:             len = T_PED;
      default:              len = T_CLEAR;
    endcase
    return len;
  endfunction

  always_comb begin
    green_len = {{(TW - _greenLightTimeWidth){1'b0}}, greenLightTime};
    if (green_len < T_MIN_G) begin
      green_len = T_MIN_G;
    end
  end

  // Alternate directions under contention; with no vehicle demand, hand green to the other side.
  always_comb begin
    opp_pend  = (last_dir == DIR_NS) ? pend_ew : pend_ns;
    same_pend = (last_dir == DIR_NS) ? pend_ns : pend_ew;
    if (!opp_pend && same_pend) begin
      sel_veh = (last_dir == DIR_NS) ? NS_GREEN : EW_GREEN;
    end else begin
      sel_veh = (last_dir == DIR_NS) ? EW_GREEN : NS_GREEN;
    end
    sel_any = pend_ped ? PED_WALK : sel_veh;
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    if (ce) begin
      if (timer > T_ONE) begin
        timer_nx = timer - T_ONE;
      end else begin
        case (state)
          ALL_RED, NS_CLEAR, EW_CLEAR: state_nx = sel_any;
          NS_GREEN:  state_nx = (pend_ew || pend_ped) ? NS_YELLOW : NS_GREEN;
          EW_GREEN:  state_nx = (pend_ns || pend_ped) ? EW_YELLOW : EW_GREEN;
          NS_YELLOW: state_nx = NS_CLEAR;
          EW_YELLOW: state_nx = EW_CLEAR;
          PED_WALK:  state_nx = sel_veh;
          default:   state_nx = ALL_RED;
        endcase
        // A green with no competing demand rests at zero instead of reloading.
        if (state_nx == state && (state == NS_GREEN || state == EW_GREEN)) begin
          timer_nx = '0;
        end else begin
          timer_nx = phase_len(state_nx, green_len);
        end
      end
    end
  end

  always_comb begin
    enter_ns    = (state_nx == NS_GREEN) && (state != NS_GREEN);
    enter_ew    = (state_nx == EW_GREEN) && (state != EW_GREEN);
    enter_ped   = (state_nx == PED_WALK) && (state != PED_WALK);
    last_dir_nx = enter_ns ? DIR_NS : (enter_ew ? DIR_EW : last_dir);
  end

  always_comb begin
    lights_nx  = L_ALL_RED;
    walk_nx    = 1'b0;
    time_ns_nx = '0;
    time_ew_nx = '0;
    case (state_nx)
      NS_GREEN:  begin lights_nx = L_NS_GREEN;  time_ns_nx = timer_nx; end
      NS_YELLOW: begin lights_nx = L_NS_YELLOW; time_ns_nx = timer_nx; end
      EW_GREEN:  begin lights_nx = L_EW_GREEN;  time_ew_nx = timer_nx; end
      EW_YELLOW: begin lights_nx = L_EW_YELLOW; time_ew_nx = timer_nx; end
      PED_WALK:  walk_nx = 1'b1;
      default:   lights_nx = L_ALL_RED;
    endcase
  end

  // A request arriving on the same clock as its flag is consumed wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ALL_RED;
      timer      <= T_CLEAR;
      last_dir   <= DIR_EW;
      pend_ns    <= 1'b0;
      pend_ew    <= 1'b0;
      pend_ped   <= 1'b0;
      lights     <= L_ALL_RED;
      walk       <= 1'b0;
      timeLeftNS <= '0;
      timeLeftEW <= '0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      last_dir   <= last_dir_nx;
      pend_ns    <= reqNS  || (pend_ns  && !enter_ns);
      pend_ew    <= reqEW  || (pend_ew  && !enter_ew);
      pend_ped   <= pedReq || (pend_ped && !enter_ped);
      lights     <= lights_nx;
      walk       <= walk_nx;
      timeLeftNS <= time_ns_nx;
      timeLeftEW <= time_ew_nx;
    end
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed scoreboard bench for traffic_phase_arbiter: the driver queues the
// hand-derived output expected after each clock, the monitor pops and compares.
module tb_traffic_phase_arbiter;

  localparam logic [5:0] AR  = 6'b100_100;
  localparam logic [5:0] NSG = 6'b001_100;
  localparam logic [5:0] NSY = 6'b010_100;
  localparam logic [5:0] EWG = 6'b100_001;
  localparam logic [5:0] EWY = 6'b100_010;

  typedef struct {
    logic [20:0] val;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       req_ns = 1'b0;
  logic       req_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic [5:0] green_time = 6'd10;
  logic [5:0] lights;
  logic       walk;
  logic [6:0] time_ns;
  logic [6:0] time_ew;

  logic [5:0] glt_drive = 6'd10;
  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fails = 0;

  traffic_phase_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ce             (ce),
    .reqNS          (req_ns),
    .reqEW          (req_ew),
    .pedReq         (ped_req),
    .greenLightTime (green_time),
    .lights         (lights),
    .walk           (walk),
    .timeLeftNS     (time_ns),
    .timeLeftEW     (time_ew)
  );

  always #5 clk = ~clk;

  // Drive one clock of inputs and queue the outputs expected after that clock's edge.
  task automatic apply_stimulus(input logic r, input logic c, input logic rn, input logic re,
                                input logic rp, input logic [5:0] el, input logic ew,
                                input logic [6:0] tn, input logic [6:0] te, input string tag);
    exp_t e;
    @(negedge clk);
    rst        = r;
    ce         = c;
    req_ns     = rn;
    req_ew     = re;
    ped_req    = rp;
    green_time = glt_drive;
    e.val = {el, ew, tn, te};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Three ce=0 clocks that must hold the outputs, then one ce=1 clock that advances them.
  task automatic apply_quad(input logic re_first,
                            input logic [5:0] hl, input logic [6:0] htn, input logic [6:0] hte,
                            input logic [5:0] nl, input logic [6:0] ntn, input logic [6:0] nte,
                            input string tag);
    apply_stimulus(1'b0, 1'b0, 1'b0, re_first, 1'b0, hl, 1'b0, htn, hte, {tag, "_hold"});
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hl, 1'b0, htn, hte, {tag, "_hold"});
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hl, 1'b0, htn, hte, {tag, "_hold"});
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, nl, 1'b0, ntn, nte, {tag, "_tick"});
  endtask

  task automatic check_output(input exp_t e);
    logic [20:0] act;
    act = {lights, walk, time_ns, time_ew};
    n_checks++;
    if (act !== e.val) begin
      n_fails++;
      $display("[TB] FAIL %s: got lights=%b walk=%b tNS=%0d tEW=%0d, want lights=%b walk=%b tNS=%0d tEW=%0d",
               e.tag, act[20:15], act[14], act[13:7], act[6:0],
               e.val[20:15], e.val[14], e.val[13:7], e.val[6:0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check_output(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset; a pedestrian request on a reset cycle must be dropped.
    apply_stimulus(1, 0, 0, 0, 1, AR, 0, 0, 0, "reset_ce0_ped");
    apply_stimulus(1, 1, 0, 0, 0, AR, 0, 0, 0, "reset");
    for (int i = 10; i >= 0; i--)
      apply_stimulus(0, 1, 0, 0, 0, NSG, 0, 7'(i), 0, "ns_countdown");
    for (int i = 0; i < 3; i++)
      apply_stimulus(0, 1, 0, 0, 0, NSG, 0, 0, 0, "ns_rest");

    // NS resting, one-cycle reqEW pulse.
    apply_stimulus(0, 1, 0, 1, 0, NSG, 0, 0, 0, "ns_rest_reqew");
    for (int i = 3; i >= 1; i--)
      apply_stimulus(0, 1, 0, 0, 0, NSY, 0, 7'(i), 0, "ns_yellow");
    apply_stimulus(0, 1, 0, 0, 0, AR, 0, 0, 0, "ns_clear");
    apply_stimulus(0, 1, 0, 0, 0, EWG, 0, 0, 10, "ew_entry");
    for (int i = 9; i >= 1; i--)
      apply_stimulus(0, 1, 0, 0, 0, EWG, 0, 0, 7'(i), "ew_countdown");
    apply_stimulus(0, 1, 0, 0, 0, EWG, 0, 0, 0, "ew_rest");

    // Short green clamp with reqEW held; mid-green greenLightTime change ignored.
    glt_drive = 6'd2;
    apply_stimulus(0, 1, 1, 0, 0, EWG, 0, 0, 0, "ew_rest_reqns");
    for (int i = 3; i >= 1; i--)
      apply_stimulus(0, 1, 0, 1, 0, EWY, 0, 0, 7'(i), "ew_yellow");
    apply_stimulus(0, 1, 0, 1, 0, AR, 0, 0, 0, "ew_clear");
    apply_stimulus(0, 1, 0, 1, 0, NSG, 0, 4, 0, "ns_min_green");
    glt_drive = 6'd20;
    for (int i = 3; i >= 1; i--)
      apply_stimulus(0, 1, 0, 1, 0, NSG, 0, 7'(i), 0, "ns_min_green_run");
    for (int i = 3; i >= 1; i--)
      apply_stimulus(0, 1, 0, 1, 0, NSY, 0, 7'(i), 0, "ns_yellow_2");
    apply_stimulus(0, 1, 0, 1, 0, AR, 0, 0, 0, "ns_clear_2");
    apply_stimulus(0, 1, 0, 0, 0, EWG, 0, 0, 20, "ew_entry_20");

    // Pedestrian plus NS request during EW green.
    glt_drive = 6'd10;
    apply_stimulus(0, 1, 1, 0, 1, EWG, 0, 0, 19, "ew_ped_req");
    for (int i = 18; i >= 1; i--)
      apply_stimulus(0, 1, 0, 0, 0, EWG, 0, 0, 7'(i), "ew_countdown_ped");
    for (int i = 3; i >= 1; i--)
      apply_stimulus(0, 1, 0, 0, 0, EWY, 0, 0, 7'(i), "ew_yellow_ped");
    apply_stimulus(0, 1, 0, 0, 0, AR, 0, 0, 0, "ew_clear_ped");
    for (int i = 0; i < 8; i++)
      apply_stimulus(0, 1, 0, 0, 0, AR, 1, 0, 0, "ped_walk");
    apply_stimulus(0, 1, 0, 0, 0, NSG, 0, 10, 0, "ns_after_ped");

    // ce on every 4th clock; reqEW pulsed on a ce=0 clock.
    for (int g = 9; g >= 1; g--)
      apply_quad(0, NSG, 7'(g + 1), 0, NSG, 7'(g), 0, "slow_ns");
    apply_quad(0, NSG, 1, 0, NSG, 0, 0, "slow_ns_rest");
    apply_quad(0, NSG, 0, 0, NSG, 0, 0, "slow_ns_rest");
    apply_quad(1, NSG, 0, 0, NSY, 3, 0, "slow_reqew");
    apply_quad(0, NSY, 3, 0, NSY, 2, 0, "slow_yellow");
    apply_quad(0, NSY, 2, 0, NSY, 1, 0, "slow_yellow");
    apply_quad(0, NSY, 1, 0, AR, 0, 0, "slow_clear");
    apply_quad(0, AR, 0, 0, EWG, 0, 10, "slow_ew_entry");

    // Reset in the middle of EW yellow with a pedestrian pending.
    apply_stimulus(0, 1, 0, 0, 1, EWG, 0, 0, 9, "ew_ped_req_2");
    for (int i = 8; i >= 1; i--)
      apply_stimulus(0, 1, 0, 0, 0, EWG, 0, 0, 7'(i), "ew_countdown_2");
    apply_stimulus(0, 1, 0, 0, 0, EWY, 0, 0, 3, "ew_yellow_3");
    apply_stimulus(0, 1, 0, 0, 0, EWY, 0, 0, 2, "ew_yellow_3");
    apply_stimulus(1, 1, 0, 0, 0, AR, 0, 0, 0, "reset_mid_yellow");
    apply_stimulus(0, 1, 0, 0, 0, NSG, 0, 10, 0, "restart_ns");
    apply_stimulus(0, 1, 0, 0, 0, NSG, 0, 9, 0, "restart_ns");

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL queue_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
